// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - serial-side and parallel-side signal bundle for uart_rx
interface uart_rx_if #(
  parameter int NB_DATA = 8
);
  logic               i_tick;
  logic               i_rx;
  logic [NB_DATA-1:0] o_data;
  logic               o_rx_done;
  logic               o_frame_err;

  modport master (
    output i_tick, i_rx,
    input  o_data, o_rx_done, o_frame_err
  );

  modport slave (
    input  i_tick, i_rx,
    output o_data, o_rx_done, o_frame_err
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - oversampling 8N1-style UART receiver with frame-error flag
module uart_rx #(
  parameter int NB_DATA = 8,
  parameter int OVS     = 16,
  parameter int SB_TICK = 16
) (
  input  logic     i_clk,
  input  logic     i_reset,
  uart_rx_if.slave bus
);

  localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
  localparam int SW   = $clog2(SMAX);
  localparam int NW   = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;

  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_BIT  = SW'(OVS - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST = NW'(NB_DATA - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [SW-1:0]      s_cnt_q, s_cnt_d;
  logic [NW-1:0]      n_cnt_q, n_cnt_d;
  logic [NB_DATA-1:0] shreg_q, shreg_d;
  logic [NB_DATA-1:0] data_q, data_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               sync1_q, rx_s_q;

  always_comb begin
    state_d = state_q;
    s_cnt_d = s_cnt_q;
    n_cnt_d = n_cnt_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    err_d   = err_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d = START;
          s_cnt_d = '0;
        end
      end
      START: begin
        if (bus.i_tick) begin
          if (s_cnt_q == S_HALF) begin
            // Still low at mid start bit: genuine start, otherwise a glitch.
            if (!rx_s_q) begin
              state_d = DATA;
              s_cnt_d = '0;
              n_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (bus.i_tick) begin
          if (s_cnt_q == S_BIT) begin
            shreg_d = {rx_s_q, shreg_q[NB_DATA-1:1]};
            s_cnt_d = '0;
            if (n_cnt_q == N_LAST) state_d = STOP;
            else                   n_cnt_d = n_cnt_q + NW'(1);
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (bus.i_tick) begin
          if (s_cnt_q == S_STOP) begin
            state_d = IDLE;
            data_d  = shreg_q;
            err_d   = ~rx_s_q;
            done_d  = 1'b1;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= IDLE;
      s_cnt_q <= '0;
      n_cnt_q <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
    end else begin
      sync1_q <= bus.i_rx;
      rx_s_q  <= sync1_q;
      state_q <= state_d;
      s_cnt_q <= s_cnt_d;
      n_cnt_q <= n_cnt_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_data      = data_q;
  assign bus.o_rx_done   = done_q;
  assign bus.o_frame_err = err_q;

endmodule
